onchip_ram_arbiter: RTL and testbench

- Shares one single-port 32-bit on-chip RAM (40192 words, 16-bit word address, byte enables, 1-cycle read latency) between two requesters.
- Requester A is the camera pixel writer and is write-only. Requester B is the Nios host and can read and write.
- Fair round-robin arbitration; one RAM operation per clock; registered command stage.
- Out-of-range accesses are trapped before they reach the RAM.

---
 rtl/onchip_ram_arbiter_if.sv | 52 +++++
 rtl/onchip_ram_arbiter.sv | 134 +++++++++++++
 tb/tb_onchip_ram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_ram_arbiter_if.sv
// Bus bundle for the on-chip RAM arbiter.
// The arbiter uses the slave modport. It takes both requester buses and the
// RAM read data as inputs, and it drives the RAM command bus.
interface onchip_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    // Requester A: camera pixel writer, write-only
    logic                  a_write;
    logic [ADDR_W-1:0]     a_address;
    logic [DATA_W-1:0]     a_writedata;
    logic                  a_waitrequest;

    // Requester B: Nios host, read/write
    logic                  b_read;
    logic                  b_write;
    logic [ADDR_W-1:0]     b_address;
    logic [DATA_W/8-1:0]   b_byteenable;
    logic [DATA_W-1:0]     b_writedata;
    logic                  b_waitrequest;
    logic [DATA_W-1:0]     b_readdata;
    logic                  b_readdatavalid;

    // RAM side
    logic                  mem_chipselect;
    logic                  mem_write;
    logic [ADDR_W-1:0]     mem_address;
    logic [DATA_W/8-1:0]   mem_byteenable;
    logic [DATA_W-1:0]     mem_writedata;
    logic                  mem_clken;
    logic [DATA_W-1:0]     mem_readdata;

    logic                  err_oor;

    modport slave (
        input  a_write, a_address, a_writedata,
        input  b_read, b_write, b_address, b_byteenable, b_writedata,
        input  mem_readdata,
        output a_waitrequest, b_waitrequest, b_readdata, b_readdatavalid,
        output mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata,
        output mem_clken, err_oor
    );

    modport master (
        output a_write, a_address, a_writedata,
        output b_read, b_write, b_address, b_byteenable, b_writedata,
        output mem_readdata,
        input  a_waitrequest, b_waitrequest, b_readdata, b_readdatavalid,
        input  mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata,
        input  mem_clken, err_oor
    );
endinterface

// File: rtl/onchip_ram_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between a write-only
// camera requester (A) and a read/write host requester (B).
// It has a registered command stage and a fixed 3-cycle read return.
// Out-of-range accesses are trapped before they reach the RAM.
module onchip_ram_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 40192
) (
    input  logic                 clk,
    input  logic                 reset,
    onchip_ram_arbiter_if.slave  bus
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              a_req;
    logic              b_req;
    logic              gnt_a;
    logic              gnt_b;
    logic              accept;
    logic              sel_write;
    logic              sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;

    // Last granted requester: 1 = B. It resets to B so that A wins the first tie.
    logic              last_grant_b_q;

    logic              cs_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              clken_q;
    logic              err_q;

    // The read pipeline tracks a B read from accept to data return.
    logic              rd_p1_q;
    logic              rd_oor_p1_q;
    logic              rd_p2_q;
    logic              rd_oor_p2_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    // Grant decision, waitrequests and the command mux for the granted requester.
    always_comb begin
        a_req   = bus.a_write;
        b_req   = bus.b_read | bus.b_write;
        gnt_a   = ~reset & a_req & (~b_req | last_grant_b_q);
        gnt_b   = ~reset & b_req & ~gnt_a;
        accept  = gnt_a | gnt_b;

        bus.a_waitrequest = reset | (a_req & ~gnt_a);
        bus.b_waitrequest = reset | (b_req & ~gnt_b);

        if (gnt_a) begin
            sel_write = 1'b1;
            sel_addr  = bus.a_address;
            sel_be    = '1;
            sel_wdata = bus.a_writedata;
        end else begin
            // Read and write high together is illegal; the write wins.
            sel_write = bus.b_write;
            sel_addr  = bus.b_address;
            sel_be    = bus.b_byteenable;
            sel_wdata = bus.b_writedata;
        end
        sel_oor = (32'(sel_addr) >= DEPTH);
    end

    // Arbitration history, the command stage and the sticky out-of-range flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_b_q <= 1'b1;
            cs_q           <= 1'b0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            clken_q        <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            clken_q <= 1'b1;
            cs_q    <= accept & ~sel_oor;
            wr_q    <= accept & ~sel_oor & sel_write;
            if (accept) begin
                last_grant_b_q <= gnt_b;
            end
            // Address and data are only loaded for forwarded commands, so a trapped
            // access never shows up on the RAM bus.
            if (accept && !sel_oor) begin
                addr_q  <= sel_addr;
                be_q    <= sel_be;
                wdata_q <= sel_wdata;
            end
            if (accept && sel_oor) begin
                err_q <= 1'b1;
            end
        end
    end

    // Read return: accept at N, RAM capture at N+1, data at N+2, valid pulse at N+3.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_p1_q     <= 1'b0;
            rd_oor_p1_q <= 1'b0;
            rd_p2_q     <= 1'b0;
            rd_oor_p2_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rd_p1_q     <= gnt_b & ~bus.b_write;
            rd_oor_p1_q <= gnt_b & ~bus.b_write & sel_oor;
            rd_p2_q     <= rd_p1_q;
            rd_oor_p2_q <= rd_oor_p1_q;
            rvalid_q    <= rd_p2_q;
            if (rd_p2_q) begin
                rdata_q <= rd_oor_p2_q ? '0 : bus.mem_readdata;
            end
        end
    end

    assign bus.mem_chipselect  = cs_q;
    assign bus.mem_write       = wr_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_byteenable  = be_q;
    assign bus.mem_writedata   = wdata_q;
    assign bus.mem_clken       = clken_q;
    assign bus.err_oor         = err_q;
    assign bus.b_readdata      = rdata_q;
    assign bus.b_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Self-checking bench for onchip_ram_arbiter.
// A 1-cycle-latency RAM lives here. A transaction-level reference model
// predicts grants, the RAM command bus, read returns and the error flag.
module tb_onchip_ram_arbiter;
    localparam int DEPTH = 40192;

    logic clk;
    logic reset;

    onchip_ram_arbiter_if ifc ();

    onchip_ram_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with byte enables and registered read data.
    logic [31:0] ram [0:DEPTH-1];
    logic [31:0] ram_rdata;
    always @(posedge clk) begin
        if (ifc.mem_clken && ifc.mem_chipselect && int'(ifc.mem_address) < DEPTH) begin
            if (ifc.mem_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (ifc.mem_byteenable[i]) begin
                        ram[ifc.mem_address][8*i +: 8] <= ifc.mem_writedata[8*i +: 8];
                    end
                end
            end else begin
                ram_rdata <= ram[ifc.mem_address];
            end
        end
    end
    assign ifc.mem_readdata = ram_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] shadow [0:DEPTH-1];
    logic [31:0] rv_due [int];  // cycle number -> expected b_readdata
    int          cyc = 0;
    bit          live = 0;
    bit          m_last_b = 1;
    bit          g_a, g_b;
    // Expected registered outputs for the current cycle (e_) and the next one (n_).
    bit          e_cs, e_wr, e_wr_known, e_after_rst, e_clken, e_err;
    logic [15:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    bit          n_cs, n_wr, n_wr_known, n_after_rst, n_clken, n_err;
    logic [15:0] n_addr;
    logic [3:0]  n_be;
    logic [31:0] n_wd;

    int          rv_count = 0;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Runs one clock cycle. Inputs are set beforehand; checks happen at the negedge.
    task automatic step();
        bit a_req, b_req, ga, gb, oor;
        int keys[$];
        @(negedge clk);
        a_req = (ifc.a_write === 1'b1);
        b_req = (ifc.b_read === 1'b1) || (ifc.b_write === 1'b1);
        ga = !reset && a_req && (!b_req || m_last_b);
        gb = !reset && b_req && !ga;
        chk("a_waitrequest", ifc.a_waitrequest, reset || (a_req && !ga));
        chk("b_waitrequest", ifc.b_waitrequest, reset || (b_req && !gb));
        if (live) begin
            chk("mem_chipselect", ifc.mem_chipselect, e_cs);
            if (e_wr_known) chk("mem_write", ifc.mem_write, e_wr);
            if (e_cs || e_after_rst) begin
                chk("mem_address", ifc.mem_address, e_addr);
                chk("mem_byteenable", ifc.mem_byteenable, e_be);
                chk("mem_writedata", ifc.mem_writedata, e_wd);
            end
            chk("mem_clken", ifc.mem_clken, e_clken);
            chk("err_oor", ifc.err_oor, e_err);
            chk("b_readdatavalid", ifc.b_readdatavalid, rv_due.exists(cyc) ? 1 : 0);
            if (rv_due.exists(cyc)) chk("b_readdata", ifc.b_readdata, rv_due[cyc]);
            else if (e_after_rst) chk("b_readdata_rst", ifc.b_readdata, 0);
        end
        if (ifc.b_readdatavalid === 1'b1) begin
            rv_count++;
            last_rdata = ifc.b_readdata;
        end

        if (reset) begin
            m_last_b = 1;
            foreach (rv_due[k]) if (k > cyc) keys.push_back(k);
            foreach (keys[i]) rv_due.delete(keys[i]);
            n_cs = 0; n_wr = 0; n_wr_known = 1; n_after_rst = 1; n_clken = 0; n_err = 0;
            n_addr = '0; n_be = '0; n_wd = '0;
        end else begin
            n_cs = 0; n_wr = 0; n_wr_known = 1; n_after_rst = 0; n_clken = 1; n_err = e_err;
            n_addr = e_addr; n_be = e_be; n_wd = e_wd;
            if (ga) begin
                oor = int'(ifc.a_address) >= DEPTH;
                m_last_b = 0;
                if (oor) begin
                    n_err = 1; n_wr_known = 0;
                end else begin
                    shadow[ifc.a_address] = ifc.a_writedata;
                    n_cs = 1; n_wr = 1;
                    n_addr = ifc.a_address; n_be = 4'hF; n_wd = ifc.a_writedata;
                end
            end
            if (gb) begin
                oor = int'(ifc.b_address) >= DEPTH;
                m_last_b = 1;
                if (ifc.b_write) begin
                    if (oor) begin
                        n_err = 1; n_wr_known = 0;
                    end else begin
                        shadow[ifc.b_address] = merge(shadow[ifc.b_address], ifc.b_writedata,
                                                      ifc.b_byteenable);
                        n_cs = 1; n_wr = 1;
                        n_addr = ifc.b_address; n_be = ifc.b_byteenable;
                        n_wd = ifc.b_writedata;
                    end
                end else begin
                    rv_due[cyc + 3] = oor ? 32'h0 : shadow[ifc.b_address];
                    if (oor) begin
                        n_err = 1; n_wr_known = 0;
                    end else begin
                        n_cs = 1; n_wr = 0;
                        n_addr = ifc.b_address; n_be = ifc.b_byteenable;
                        n_wd = ifc.b_writedata;
                    end
                end
            end
        end
        g_a = ga;
        g_b = gb;
        @(posedge clk);
        #1;
        cyc++;
        e_cs = n_cs; e_wr = n_wr; e_wr_known = n_wr_known; e_after_rst = n_after_rst;
        e_clken = n_clken; e_err = n_err; e_addr = n_addr; e_be = n_be; e_wd = n_wd;
        live = 1;
    endtask

    task automatic idle(input int n);
        ifc.a_write = 0; ifc.b_read = 0; ifc.b_write = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 16'(DEPTH + $urandom_range(0, 65535 - DEPTH));
        return 16'($urandom_range(0, 31));
    endfunction

    initial begin
        int rv0;
        int op;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        ram_rdata = '0;
        ram[16] = 32'h1234_5678;
        shadow[16] = 32'h1234_5678;
        reset = 1;
        ifc.a_write = 0; ifc.a_address = '0; ifc.a_writedata = '0;
        ifc.b_read = 0; ifc.b_write = 0; ifc.b_address = '0;
        ifc.b_byteenable = '0; ifc.b_writedata = '0;
        step();
        step();
        reset = 0;
        step();

        // Single B read of a preloaded word.
        ifc.b_read = 1; ifc.b_address = 16'h0010; ifc.b_byteenable = 4'hF;
        step();
        idle(4);
        chk("t1_rdata", last_rdata, 32'h1234_5678);

        // Contention: both requesters asserted for 6 cycles.
        rv0 = rv_count;
        ifc.a_write = 1; ifc.a_address = 16'h0020; ifc.a_writedata = 32'hCAFE_0001;
        ifc.b_read = 1; ifc.b_address = 16'h0010; ifc.b_byteenable = 4'hF;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t2_alternate", g_a, (i % 2 == 0) ? 1 : 0);
        end
        idle(4);
        chk("t2_rv_pulses", rv_count - rv0, 3);

        // B byte write over zero, then read back.
        ifc.b_write = 1; ifc.b_address = 16'h0100; ifc.b_byteenable = 4'b0101;
        ifc.b_writedata = 32'hAABB_CCDD;
        step();
        ifc.b_write = 0; ifc.b_read = 1; ifc.b_byteenable = 4'hF;
        step();
        idle(4);
        chk("t3_rdata", last_rdata, 32'h00BB_00DD);

        // Out-of-range: A writes 40192, then B reads 0xFFFF.
        rv0 = rv_count;
        ifc.a_write = 1; ifc.a_address = 16'(DEPTH); ifc.a_writedata = 32'hDEAD_BEEF;
        step();
        ifc.a_write = 0; ifc.b_read = 1; ifc.b_address = 16'hFFFF;
        step();
        idle(4);
        chk("t4_err_oor", ifc.err_oor, 1);
        chk("t4_rv_pulse", rv_count - rv0, 1);
        chk("t4_rdata", last_rdata, 32'h0);

        // Reset asserted the cycle after a B read is accepted.
        rv0 = rv_count;
        ifc.b_read = 1; ifc.b_address = 16'h0010;
        step();
        ifc.b_read = 0; reset = 1;
        step();
        reset = 0;
        step();
        step();
        step();
        chk("t5_no_rv", rv_count - rv0, 0);
        chk("t5_err_cleared", ifc.err_oor, 0);
        ifc.a_write = 1; ifc.a_address = 16'h0030; ifc.a_writedata = 32'h0000_0A0A;
        ifc.b_read = 1; ifc.b_address = 16'h0010;
        step();
        chk("t5_first_tie_a", g_a, 1);
        idle(4);

        // Streaming: A alone writes 0..255 on consecutive cycles.
        for (int i = 0; i < 256; i++) begin
            ifc.a_write = 1; ifc.a_address = 16'(i); ifc.a_writedata = 32'(i);
            step();
            if (i == 0 || i == 255) chk("t6_stream_grant", g_a, 1);
        end
        ifc.a_write = 0;
        ifc.b_read = 1; ifc.b_address = 16'd200; ifc.b_byteenable = 4'hF;
        step();
        idle(4);
        chk("t6_rdata", last_rdata, 32'd200);

        // Randomized traffic with level-held requests.
        for (int k = 0; k < 400; k++) begin
            if (!ifc.a_write || g_a) begin
                ifc.a_write = ($urandom_range(0, 2) != 0);
                ifc.a_address = rand_addr();
                ifc.a_writedata = $urandom();
            end
            if (!(ifc.b_read || ifc.b_write) || g_b) begin
                op = $urandom_range(0, 7);
                ifc.b_read = (op == 1 || op == 2 || op == 3 || op == 7);
                ifc.b_write = (op == 4 || op == 5 || op == 7);
                ifc.b_address = rand_addr();
                ifc.b_byteenable = 4'($urandom_range(0, 15));
                ifc.b_writedata = $urandom();
            end
            step();
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
